// File: rtl/adv_counter_core.sv
// Multi-digit up/down hex counter with per-digit wrap limits and serial 7-seg frames.
// Optional ADVCNT_LZB_EN blanks leading zero digits (digit 0 always shown).
module adv_counter_core #(
  parameter int DIGITS    = 4,
  parameter int SHIFT_DIV = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DIGITS-1:0]     inc_in,
  input  logic                  up_dn,
  input  logic                  carry_en,
  input  logic                  max_en,
  input  logic                  limit_load,
  input  logic                  clr,
  output logic [4*DIGITS-1:0]   cnt_out,
  output logic                  ovf,
  output logic [DIGITS-1:0]     seg_data,
  output logic                  seg_clk,
  output logic                  seg_latch,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LATCH
  } state_t;

  localparam logic [7:0] DIV_M1 = 8'(SHIFT_DIV - 1);

  logic [DIGITS-1:0]      s1, s2, s3;
  logic [DIGITS-1:0]      inc_edge;
  logic [DIGITS-1:0][3:0] cnt_q, cnt_d, lim_q;
  logic [DIGITS-1:0][7:0] frame, sh;
  logic                   top_co;
  logic                   evt;
  logic                   pending;
  state_t                 state;
  logic [7:0]             div_q;
  logic [2:0]             bit_q;

  function automatic logic [7:0] hex7(input logic [3:0] d);
    logic [7:0] f;
    unique case (d)
      4'h0: f = 8'h3F;
      4'h1: f = 8'h06;
      4'h2: f = 8'h5B;
      4'h3: f = 8'h4F;
      4'h4: f = 8'h66;
      4'h5: f = 8'h6D;
      4'h6: f = 8'h7D;
      4'h7: f = 8'h07;
      4'h8: f = 8'h7F;
      4'h9: f = 8'h6F;
      4'hA: f = 8'h77;
      4'hB: f = 8'h7C;
      4'hC: f = 8'h39;
      4'hD: f = 8'h5E;
      4'hE: f = 8'h79;
      4'hF: f = 8'h71;
    endcase
    return f;
  endfunction

  assign inc_edge = s2 & ~s3;
  assign cnt_out  = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= inc_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Carry ripples through all digits in one cycle; an own edge
  // coinciding with an incoming carry still yields a single step.
  always_comb begin
    logic       c;
    logic       step;
    logic [3:0] lim;
    cnt_d = cnt_q;
    c     = 1'b0;
    step  = 1'b0;
    lim   = 4'hF;
    for (int j = 0; j < DIGITS; j++) begin
      lim  = max_en ? lim_q[j] : 4'hF;
      step = inc_edge[j] | (carry_en & c);
      c    = 1'b0;
      if (step) begin
        if (up_dn) begin
          if (cnt_q[j] >= lim) begin
            cnt_d[j] = 4'h0;
            c        = 1'b1;
          end else begin
            cnt_d[j] = cnt_q[j] + 4'd1;
          end
        end else begin
          if (cnt_q[j] == 4'h0) begin
            cnt_d[j] = lim;
            c        = 1'b1;
          end else begin
            cnt_d[j] = cnt_q[j] - 4'd1;
          end
        end
      end
    end
    top_co = c;
  end

  assign evt = clr | (cnt_d != cnt_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      lim_q <= '1;
      ovf   <= 1'b0;
    end else begin
      cnt_q <= clr ? '0 : cnt_d;
      ovf   <= ~clr & top_co;
      if (limit_load) lim_q <= cnt_q;
    end
  end

`ifdef ADVCNT_LZB_EN
  always_comb begin
    logic [DIGITS:0] hi;
    hi    = '0;
    frame = '0;
    for (int j = DIGITS - 1; j >= 0; j--) begin
      hi[j]    = hi[j+1] | (cnt_q[j] != 4'h0);
      frame[j] = (j == 0 || hi[j]) ? hex7(cnt_q[j]) : 8'h00;
    end
  end
`else
  always_comb begin
    frame = '0;
    for (int j = 0; j < DIGITS; j++) begin
      frame[j] = hex7(cnt_q[j]);
    end
  end
`endif

  always_comb begin
    seg_data = '0;
    for (int j = 0; j < DIGITS; j++) begin
      seg_data[j] = sh[j][7];
    end
  end

  // pending set wins over the clear on frame start: the snapshot
  // taken in that cycle holds the pre-change value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pending   <= 1'b1;
      busy      <= 1'b0;
      seg_clk   <= 1'b0;
      seg_latch <= 1'b0;
      div_q     <= '0;
      bit_q     <= '0;
      sh        <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          pending <= pending | evt;
          if (pending && !busy) begin
            pending <= evt;
            state   <= SHIFT;
            busy    <= 1'b1;
            seg_clk <= 1'b0;
            div_q   <= '0;
            bit_q   <= '0;
            sh      <= frame;
          end
        end
        SHIFT: begin
          pending <= pending | evt;
          if (div_q == DIV_M1) begin
            div_q <= '0;
            if (!seg_clk) begin
              seg_clk <= 1'b1;
            end else begin
              seg_clk <= 1'b0;
              if (bit_q == 3'd7) begin
                state     <= LATCH;
                seg_latch <= 1'b1;
                sh        <= '0;
              end else begin
                bit_q <= bit_q + 3'd1;
                for (int j = 0; j < DIGITS; j++) begin
                  sh[j] <= {sh[j][6:0], 1'b0};
                end
              end
            end
          end else begin
            div_q <= div_q + 8'd1;
          end
        end
        LATCH: begin
          pending <= pending | evt;
          if (div_q == DIV_M1) begin
            state     <= IDLE;
            seg_latch <= 1'b0;
            busy      <= 1'b0;
            div_q     <= '0;
          end else begin
            div_q <= div_q + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
